// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader:
// state encoding, word geometry, header width and the word-address helper.
package instr_loader_pkg;

    // 3-bit state encoding shared by the loader FSM and anything that decodes it
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LEN0 = 3'd1;
    localparam logic [2:0] ST_LEN1 = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_CHK  = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;
    localparam logic [2:0] ST_ERR  = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_LEN0 = ST_LEN0,
        S_LEN1 = ST_LEN1,
        S_DATA = ST_DATA,
        S_CHK  = ST_CHK,
        S_DONE = ST_DONE,
        S_ERR  = ST_ERR
    } state_e;

    localparam int WORD_BYTES = 4;
    localparam int BIDX_W     = $clog2(WORD_BYTES);
    // width of the little-endian word-count header
    localparam int HDR_W      = 16;

    // Byte address of word idx; wraps modulo 2^32
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/instr_mem_loader_word_assembler.sv
// word_assembler: packs consecutive stream bytes little-endian into a
// 32-bit word and pulses word_valid the cycle after the 4th byte lands.
module word_assembler
    import instr_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        fill_last,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [BIDX_W-1:0] byte_idx;

    // next accepted byte completes the word
    assign fill_last = (byte_idx == BIDX_W'(WORD_BYTES - 1));

    // byte lane fill, byte index and one-cycle completion pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx   <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (clr) begin
                byte_idx <= '0;
            end else if (in_valid) begin
                word[{byte_idx, 3'b000} +: 8] <= in_byte;
                byte_idx <= byte_idx + BIDX_W'(1);
                if (fill_last)
                    word_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: streams a length-prefixed little-endian image into the
// writable instruction memory and holds the CPU until the image is in.
// Optional feature macro: LOADER_CHECKSUM_EN (trailing XOR checksum byte).
module instr_mem_loader
    import instr_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 1024,
    parameter int          CNT_W     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic        mem_we,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    state_e            state;
    logic [7:0]        len_lo;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  word_idx;
    logic [HDR_W-1:0]  len_full;
    logic              take;
    logic              data_take;
    logic              restart;
    logic              fill_last;
    logic              word_valid;
    logic [31:0]       word;
    logic              last_word;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    assign take      = s_valid && s_ready;
    assign data_take = take && (state == S_DATA);
    assign restart   = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
    assign len_full  = {s_data, len_lo};
    assign last_word = (word_idx == count - CNT_W'(1));

    word_assembler u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (restart),
        .in_valid   (data_take),
        .in_byte    (s_data),
        .fill_last  (fill_last),
        .word_valid (word_valid),
        .word       (word)
    );

    // the write strobe and data come straight from the assembler's registers
    assign mem_we    = word_valid;
    assign mem_wdata = word;

    // loader FSM: header capture, word addressing, status flags, s_ready decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            s_ready   <= 1'b0;
            mem_waddr <= BASE_ADDR;
            cpu_hold  <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            len_lo    <= '0;
            count     <= '0;
            word_idx  <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state    <= S_LEN0;
                        s_ready  <= 1'b1;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        cpu_hold <= 1'b1;
                        word_idx <= '0;
`ifdef LOADER_CHECKSUM_EN
                        csum     <= '0;
`endif
                    end
                end
                S_LEN0: begin
                    if (take) begin
                        len_lo <= s_data;
                        state  <= S_LEN1;
                    end
                end
                S_LEN1: begin
                    if (take) begin
                        count <= CNT_W'(len_full);
                        if (len_full == '0) begin
`ifdef LOADER_CHECKSUM_EN
                            state    <= S_CHK;
`else
                            state    <= S_DONE;
                            s_ready  <= 1'b0;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
`endif
                        end else if (32'(len_full) > 32'(MAX_WORDS)) begin
                            state   <= S_ERR;
                            s_ready <= 1'b0;
                            err     <= 1'b1;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (take) begin
`ifdef LOADER_CHECKSUM_EN
                        csum <= csum ^ s_data;
`endif
                        if (fill_last) begin
                            // address is registered alongside the strobe the assembler raises
                            mem_waddr <= word_addr(BASE_ADDR, 32'(word_idx));
                            word_idx  <= word_idx + CNT_W'(1);
                            if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                                state    <= S_CHK;
`else
                                state    <= S_DONE;
                                s_ready  <= 1'b0;
                                done     <= 1'b1;
                                cpu_hold <= 1'b0;
`endif
                            end
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (take) begin
                        s_ready <= 1'b0;
                        if (s_data == csum) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state   <= S_IDLE;
                    s_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: stimulus pushes expected writes,
// an independent monitor pops and compares on every mem_we pulse.
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_ready;
    logic        mem_we;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q[$];
    logic [31:0] img[16];

    instr_mem_loader #(
        .BASE_ADDR (32'h0000_0000),
        .MAX_WORDS (256),
        .CNT_W     (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: every write must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr %h data %h expected none", mem_waddr, mem_wdata);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("write_addr", mem_waddr, e[63:32]);
                chk("write_data", mem_wdata, e[31:0]);
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        s_data  = b;
        s_valid = 1'b1;
        while (s_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: got s_ready=0 for 50 cycles expected 1");
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    // load img[0..n-1]; gaps=1 inserts random idle cycles before ~50% of bytes
    task automatic run_image(input int n, input bit gaps);
        logic [7:0] cs;
        logic [7:0] b;
        cs = 8'h00;
        pulse_start();
        send_byte(8'(n));
        send_byte(8'(n >> 8));
        for (int w = 0; w < n; w++) begin
            exp_q.push_back({32'(w) * 32'd4, img[w]});
            for (int k = 0; k < 4; k++) begin
                if (gaps && $urandom_range(0, 1) == 0)
                    repeat (1 + $urandom_range(0, 2)) @(negedge clk);
                b = img[w][8*k +: 8];
                cs = cs ^ b;
`ifndef LOADER_CHECKSUM_EN
                if (w == n - 1 && k == 3) begin
                    chk("hold_before_last", {31'd0, cpu_hold}, 32'd1);
                    chk("done_before_last", {31'd0, done}, 32'd0);
                end
`endif
                send_byte(b);
                if (k == 3)
                    chk("we_latency", {31'd0, mem_we}, 32'd1);
            end
        end
`ifdef LOADER_CHECKSUM_EN
        chk("hold_before_chk", {31'd0, cpu_hold}, 32'd1);
        send_byte(cs);
`endif
        chk("done_set", {31'd0, done}, 32'd1);
        chk("hold_released", {31'd0, cpu_hold}, 32'd0);
        chk("err_clear", {31'd0, err}, 32'd0);
        chk("ready_low_done", {31'd0, s_ready}, 32'd0);
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_waddr", mem_waddr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_hold", {31'd0, cpu_hold}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // two-word image
        img[0] = 32'h00A0_0213;
        img[1] = 32'h0000_0063;
        run_image(2, 1'b0);

        // zero-length image
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h00);
`ifdef LOADER_CHECKSUM_EN
        chk("zero_chk_ready", {31'd0, s_ready}, 32'd1);
        chk("zero_chk_notdone", {31'd0, done}, 32'd0);
        send_byte(8'h00);
`endif
        chk("zero_done", {31'd0, done}, 32'd1);
        chk("zero_hold", {31'd0, cpu_hold}, 32'd0);

        // oversize length 0x0104 = 260 > 256
        pulse_start();
        send_byte(8'h04);
        send_byte(8'h01);
        chk("big_err", {31'd0, err}, 32'd1);
        chk("big_hold", {31'd0, cpu_hold}, 32'd1);
        chk("big_ready", {31'd0, s_ready}, 32'd0);
        chk("big_done", {31'd0, done}, 32'd0);
        repeat (4) @(negedge clk);

        // 16-word image, gapless then with random valid gaps
        for (int i = 0; i < 16; i++)
            img[i] = 32'h1000_0000 + 32'(i) * 32'h0102_0304;
        run_image(16, 1'b0);
        run_image(16, 1'b1);

        // reset in the middle of word 3
        pulse_start();
        send_byte(8'h04);
        send_byte(8'h00);
        for (int w = 0; w < 3; w++) begin
            exp_q.push_back({32'(w) * 32'd4, img[w]});
            for (int k = 0; k < 4; k++)
                send_byte(img[w][8*k +: 8]);
        end
        send_byte(img[3][7:0]);
        send_byte(img[3][15:8]);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", {31'd0, s_ready}, 32'd0);
        chk("midrst_we", {31'd0, mem_we}, 32'd0);
        chk("midrst_waddr", mem_waddr, 32'h0);
        chk("midrst_wdata", mem_wdata, 32'h0);
        chk("midrst_hold", {31'd0, cpu_hold}, 32'd1);
        chk("midrst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        img[0] = 32'hDEAD_BEEF;
        run_image(1, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        // good checksum B1, then bad checksum B0
        img[0] = 32'h00A0_0213;
        run_image(1, 1'b0);
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        exp_q.push_back({32'h0, 32'h00A0_0213});
        send_byte(8'h13);
        send_byte(8'h02);
        send_byte(8'hA0);
        send_byte(8'h00);
        send_byte(8'hB0);
        chk("badcs_err", {31'd0, err}, 32'd1);
        chk("badcs_done", {31'd0, done}, 32'd0);
        chk("badcs_hold", {31'd0, cpu_hold}, 32'd1);
`endif

        repeat (4) @(negedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
